// File: rtl/eth_out_arb.sv
// Packet-granular round-robin arbiter: two input-queue readers share one registered output port.
// Grants hold from SOP to EOP; over-length packets are cut and orphan words are drained in IDLE.
module eth_out_arb #(
   parameter int MAX_PKT_WORDS = 64,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic [1:0]       inValid,
   input  logic [33:0]      inData0,
   input  logic [33:0]      inData1,
   output logic [1:0]       inReady,
   output logic             outValid,
   output logic [31:0]      outData,
   output logic             outSop,
   output logic             outEop,
   input  logic             outReady,
   output logic             busy,
   output logic             grantIdx,
   output logic [CNT_W-1:0] pktCnt0,
   output logic [CNT_W-1:0] pktCnt1,
   output logic             errLen,
   output logic             errSop
);

   localparam int WCW = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;
   localparam logic [WCW-1:0] LAST_WC = WCW'(MAX_PKT_WORDS - 1);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic [WCW-1:0]   wc_q, wc_d;
   logic             ov_q, ov_d;
   logic [31:0]      od_q, od_d;
   logic             os_q, os_d;
   logic             oe_q, oe_d;
   logic [CNT_W-1:0] c0_q, c0_d;
   logic [CNT_W-1:0] c1_q, c1_d;
   logic             elen_q, elen_d;
   logic             esop_q, esop_d;

   logic [1:0]       sop;
   logic [1:0]       cand;
   logic [1:0]       ready;
   logic [33:0]      gword;
   logic             acc_ok;
   logic             accept;

   // Handshake: an input word moves when inValid[i] && inReady[i]; the output word
   // moves when outValid && outReady. The output register refills in the same cycle it drains.
   always_comb begin
      sop     = {inData1[32], inData0[32]};
      cand    = inValid & sop;
      gword   = grant_q ? inData1 : inData0;
      acc_ok  = !ov_q || outReady;
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wc_d    = wc_q;
      ov_d    = ov_q;
      od_d    = od_q;
      os_d    = os_q;
      oe_d    = oe_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      elen_d  = 1'b0;
      esop_d  = 1'b0;
      ready   = 2'b00;
      accept  = 1'b0;

      if (ov_q && outReady) ov_d = 1'b0;

      case (state_q)
         IDLE: begin
            // Non-SOP heads are orphans; they are discarded while the SOP waits a bubble.
            ready  = inValid & ~sop;
            esop_d = |(inValid & ~sop);
            if (cand != 2'b00) begin
               state_d = XFER;
               grant_d = (cand == 2'b11) ? ~last_q : cand[1];
            end
         end
         XFER: begin
            ready  = grant_q ? {acc_ok, 1'b0} : {1'b0, acc_ok};
            accept = inValid[grant_q] && acc_ok;
            if (accept) begin
               ov_d = 1'b1;
               od_d = gword[31:0];
               os_d = gword[32];
               oe_d = gword[33];
               wc_d = wc_q + 1'b1;
               if (gword[33] || wc_q == LAST_WC) begin
                  oe_d    = 1'b1;
                  elen_d  = !gword[33];
                  state_d = IDLE;
                  last_d  = grant_q;
                  wc_d    = '0;
                  if (grant_q) begin
                     if (c1_q != '1) c1_d = c1_q + 1'b1;
                  end else begin
                     if (c0_q != '1) c0_d = c0_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      inReady = resetN ? ready : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         wc_q    <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         os_q    <= 1'b0;
         oe_q    <= 1'b0;
         c0_q    <= '0;
         c1_q    <= '0;
         elen_q  <= 1'b0;
         esop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wc_q    <= wc_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         os_q    <= os_d;
         oe_q    <= oe_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         elen_q  <= elen_d;
         esop_q  <= esop_d;
      end
   end

   assign outValid = ov_q;
   assign outData  = od_q;
   assign outSop   = os_q;
   assign outEop   = oe_q;
   assign busy     = (state_q == XFER);
   assign grantIdx = grant_q;
   assign pktCnt0  = c0_q;
   assign pktCnt1  = c1_q;
   assign errLen   = elen_q;
   assign errSop   = esop_q;

endmodule

// File: tb/tb_eth_out_arb.sv
// Bench for eth_out_arb: directed scenarios plus random packet traffic, checked every cycle
// against a packet-level reference model and an expected-word queue.
module tb_eth_out_arb;

   localparam int MAXW = 4;
   localparam int CW   = 2;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic [1:0]    inValid = 2'b00;
   logic [33:0]   inData0 = '0;
   logic [33:0]   inData1 = '0;
   logic [1:0]    inReady;
   logic          outValid;
   logic [31:0]   outData;
   logic          outSop;
   logic          outEop;
   logic          outReady = 1'b0;
   logic          busy;
   logic          grantIdx;
   logic [CW-1:0] pktCnt0;
   logic [CW-1:0] pktCnt1;
   logic          errLen;
   logic          errSop;

   always #5 clk = ~clk;

   eth_out_arb #(.MAX_PKT_WORDS(MAXW), .CNT_W(CW)) dut (
      .clk(clk), .resetN(resetN), .inValid(inValid), .inData0(inData0), .inData1(inData1),
      .inReady(inReady), .outValid(outValid), .outData(outData), .outSop(outSop),
      .outEop(outEop), .outReady(outReady), .busy(busy), .grantIdx(grantIdx),
      .pktCnt0(pktCnt0), .pktCnt1(pktCnt1), .errLen(errLen), .errSop(errSop)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Sources, stimulus controls and observation counters
   logic [33:0] src0[$];
   logic [33:0] src1[$];
   logic [33:0] exp_q[$];
   logic [7:0]  sop_own[$];
   bit   [1:0]  cons = 2'b00;
   int          vld_pct = 100;
   bit          rst_drv = 1'b0;
   int          hs_cnt, elen_cnt, esop_cnt, busy_cnt;

   // Reference model: packet owner, words taken so far, output word, counters
   bit          m_busy = 0, m_gnt = 0, m_last = 1;
   int          m_wc = 0;
   bit          m_ov = 0, m_os = 0, m_oe = 0;
   logic [31:0] m_od = '0;
   int          m_c0 = 0, m_c1 = 0;
   bit          m_elen = 0, m_esop = 0;
   localparam int CMAX = (1 << CW) - 1;

   task automatic cycle(input bit ordy);
      logic [1:0]  rdy;
      logic [1:0]  sp;
      logic [33:0] w;
      @(negedge clk);
      if (cons[0]) begin
         if (src0.size() > 0) void'(src0.pop_front());
         inValid[0] = 1'b0;
      end
      if (cons[1]) begin
         if (src1.size() > 0) void'(src1.pop_front());
         inValid[1] = 1'b1 & 1'b0;
      end
      cons = 2'b00;
      if (src0.size() == 0) begin
         inValid[0] = 1'b0;
         inData0    = {2'($urandom), $urandom};
      end else begin
         if (!inValid[0]) inValid[0] = ($urandom_range(99) < vld_pct);
         inData0 = src0[0];
      end
      if (src1.size() == 0) begin
         inValid[1] = 1'b0;
         inData1    = {2'($urandom), $urandom};
      end else begin
         if (!inValid[1]) inValid[1] = ($urandom_range(99) < vld_pct);
         inData1 = src1[0];
      end
      outReady = ordy;
      resetN   = rst_drv;
      #1;
      sp = {inData1[32], inData0[32]};
      if (!rst_drv) rdy = 2'b00;
      else if (!m_busy) rdy = inValid & ~sp;
      else begin
         rdy = 2'b00;
         rdy[m_gnt] = !m_ov || ordy;
      end
      chk("inReady", inReady, rdy);
      if (rst_drv && m_ov && ordy) begin
         hs_cnt++;
         if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            w = exp_q.pop_front();
            chk("sb_word", {outEop, outSop, outData}, w);
         end
         if (outSop) sop_own.push_back(outData[31:24]);
      end
      cons = inValid & rdy;
      if (!rst_drv) begin
         m_busy = 0; m_gnt = 0; m_last = 1; m_wc = 0;
         m_ov = 0; m_od = '0; m_os = 0; m_oe = 0;
         m_c0 = 0; m_c1 = 0; m_elen = 0; m_esop = 0;
         exp_q.delete();
      end else begin
         m_elen = 0;
         m_esop = 0;
         if (m_ov && ordy) m_ov = 0;
         if (!m_busy) begin
            m_esop = |(inValid & ~sp);
            if ((inValid & sp) == 2'b11) begin
               m_busy = 1; m_gnt = !m_last;
            end else if ((inValid & sp) != 2'b00) begin
               m_busy = 1; m_gnt = inValid[1] && sp[1];
            end
         end else if (inValid[m_gnt] && rdy[m_gnt]) begin
            w = m_gnt ? inData1 : inData0;
            m_wc++;
            m_ov = 1; m_od = w[31:0]; m_os = w[32]; m_oe = w[33];
            if (w[33] || m_wc == MAXW) begin
               m_oe = 1; m_elen = !w[33]; m_busy = 0; m_last = m_gnt; m_wc = 0;
               if (m_gnt) begin if (m_c1 < CMAX) m_c1++; end
               else begin if (m_c0 < CMAX) m_c0++; end
            end
            exp_q.push_back({m_oe, m_os, m_od});
         end
      end
      @(posedge clk);
      #1;
      chk("outValid", outValid, m_ov);
      chk("outData", outData, m_od);
      chk("outSop", outSop, m_os);
      chk("outEop", outEop, m_oe);
      chk("busy", busy, m_busy);
      chk("grantIdx", grantIdx, m_gnt);
      chk("pktCnt0", pktCnt0, m_c0);
      chk("pktCnt1", pktCnt1, m_c1);
      chk("errLen", errLen, m_elen);
      chk("errSop", errSop, m_esop);
      if (errLen) elen_cnt++;
      if (errSop) esop_cnt++;
      if (busy) busy_cnt++;
   endtask

   task automatic push_word(input int req, input logic [33:0] w);
      if (req == 0) src0.push_back(w);
      else src1.push_back(w);
   endtask

   task automatic push_pkt(input int req, input int len, input logic [31:0] first);
      logic [31:0] d;
      for (int k = 0; k < len; k++) begin
         d = (k == 0) ? first : {8'(req), 24'($urandom)};
         push_word(req, {(k == len - 1), (k == 0), d});
      end
   endtask

   task automatic flush_src();
      src0.delete();
      src1.delete();
      cons = 2'b00;
   endtask

   task automatic do_reset();
      rst_drv = 1'b0;
      flush_src();
      cycle(1'b1);
      cycle(1'b1);
      rst_drv = 1'b1;
      hs_cnt = 0; elen_cnt = 0; esop_cnt = 0; busy_cnt = 0;
      sop_own.delete();
   endtask

   task automatic run_drain(input int rdy_pct, input int budget);
      int n = 0;
      while ((src0.size() > 0 || src1.size() > 0 || m_busy || m_ov) && n < budget) begin
         cycle($urandom_range(99) < rdy_pct);
         n++;
      end
      chk("drain_timeout", (n >= budget), 0);
   endtask

   initial begin
      logic [33:0] words[4];
      logic [7:0]  own_exp[4];
      int          n;

      // Single packet: latency, flags, busy length, counter
      do_reset();
      chk("rst_outValid", outValid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grantIdx", grantIdx, 0);
      chk("rst_pktCnt0", pktCnt0, 0);
      push_pkt(0, 4, 32'h0000BEEF);
      cycle(1'b1);
      chk("t1_bubble", outValid, 0);
      chk("t1_busy", busy, 1);
      cycle(1'b1);
      chk("t1_first", {outValid, outSop, outEop, outData}, {1'b1, 1'b1, 1'b0, 32'h0000BEEF});
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b1);
      chk("t1_last", {outValid, outSop, outEop}, 3'b101);
      run_drain(100, 50);
      chk("t1_cnt", pktCnt0, 1);
      chk("t1_busy_len", busy_cnt, 4);

      // Ties alternate, starting with requester 0
      do_reset();
      push_pkt(0, 3, 32'h00000000);
      push_pkt(1, 2, 32'h01000000);
      push_pkt(0, 2, 32'h00000000);
      push_pkt(1, 3, 32'h01000000);
      run_drain(100, 100);
      own_exp = '{8'd0, 8'd1, 8'd0, 8'd1};
      chk("tie_pkts", sop_own.size(), 4);
      for (int i = 0; i < 4 && i < sop_own.size(); i++) chk("tie_order", sop_own[i], own_exp[i]);

      // Backpressure mid-packet
      do_reset();
      for (int k = 0; k < 4; k++)
         words[k] = {(k == 3), (k == 0), 8'd0, 24'($urandom)};
      for (int k = 0; k < 4; k++) push_word(0, words[k]);
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b0);
      cycle(1'b0);
      chk("bp_hold", {outValid, outEop, outSop, outData}, {1'b1, words[1]});
      chk("bp_inReady", inReady, 2'b00);
      run_drain(100, 50);
      chk("bp_words", hs_cnt, 4);
      chk("bp_cnt", pktCnt0, 1);

      // Over-length packet from requester 1
      do_reset();
      push_pkt(1, 6, 32'h01000000);
      run_drain(100, 60);
      chk("ol_words", hs_cnt, 4);
      chk("ol_errLen", elen_cnt, 1);
      chk("ol_errSop", esop_cnt, 2);
      chk("ol_cnt", pktCnt1, 1);

      // Reset mid-packet, then a fresh packet
      do_reset();
      push_pkt(0, 4, 32'h00000000);
      n = 0;
      while (hs_cnt < 2 && n < 20) begin
         cycle(1'b1);
         n++;
      end
      chk("rm_reach", (hs_cnt >= 2), 1);
      rst_drv = 1'b0;
      flush_src();
      cycle(1'b1);
      rst_drv = 1'b1;
      chk("rm_outValid", outValid, 0);
      chk("rm_busy", busy, 0);
      chk("rm_cnts", {pktCnt0, pktCnt1}, 0);
      hs_cnt = 0;
      push_pkt(0, 2, 32'h00000000);
      run_drain(100, 50);
      chk("rm_words", hs_cnt, 2);
      chk("rm_cnt", pktCnt0, 1);

      // Counter saturation
      do_reset();
      for (int i = 0; i < 5; i++) push_pkt(0, 1, {8'd0, 24'($urandom)});
      run_drain(100, 80);
      chk("sat_cnt", pktCnt0, 3);

      // Random traffic with orphans, over-length packets and backpressure
      do_reset();
      vld_pct = 70;
      for (int r = 0; r < 60; r++) begin
         int req;
         req = $urandom_range(1);
         if ($urandom_range(9) == 0) push_word(req, {1'($urandom), 1'b0, 8'(req), 24'($urandom)});
         push_pkt(req, $urandom_range(1, 6), {8'(req), 24'($urandom)});
      end
      run_drain(75, 5000);
      vld_pct = 100;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
